// File: rtl/rle_pkg.sv
// Shared types and descriptor pack/unpack helpers for the RLE encoder/decoder family.
package rle_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } rle_state_t;

   // Widest symbol or count field the helpers can carry.
   localparam int unsigned MaxFieldW = 32;

   // Container wide enough for {last, count, symbol} at the maximum field widths.
   typedef logic [2*MaxFieldW:0] rle_word_t;

   typedef struct packed {
      logic                 last;
      logic [MaxFieldW-1:0] count;
      logic [MaxFieldW-1:0] symbol;
   } rle_fields_t;

   // Packs {last, count, symbol} LSB-aligned; count and symbol must already fit their widths.
   function automatic rle_word_t rle_pack(input logic                 last,
                                          input logic [MaxFieldW-1:0] count,
                                          input logic [MaxFieldW-1:0] symbol,
                                          input int unsigned          sym_w,
                                          input int unsigned          cnt_w);
      return (rle_word_t'(last) << (sym_w + cnt_w)) |
             (rle_word_t'(count) << sym_w) |
             rle_word_t'(symbol);
   endfunction

   // Splits an LSB-aligned descriptor back into its fields.
   function automatic rle_fields_t rle_unpack(input rle_word_t   word,
                                              input int unsigned sym_w,
                                              input int unsigned cnt_w);
      rle_word_t   sym_mask;
      rle_word_t   cnt_mask;
      rle_fields_t f;
      sym_mask = (rle_word_t'(1) << sym_w) - rle_word_t'(1);
      cnt_mask = (rle_word_t'(1) << cnt_w) - rle_word_t'(1);
      f.symbol = MaxFieldW'(word & sym_mask);
      f.count  = MaxFieldW'((word >> sym_w) & cnt_mask);
      f.last   = 1'(word >> (sym_w + cnt_w));
      return f;
   endfunction

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry output register: accepts a push whenever it is empty or being drained.
module rle_out_reg
   import rle_pkg::*;
#(
   parameter int unsigned DataW = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [DataW-1:0] data_i,
   output logic             can_push_o,
   output logic [DataW-1:0] out_data_o,
   output logic             out_vld_o,
   input  logic             out_rdy_i
);

   logic             vld_q, vld_d;
   logic [DataW-1:0] data_q, data_d;

   assign can_push_o = !vld_q || out_rdy_i;
   assign out_data_o = data_q;
   assign out_vld_o  = vld_q;

   // Next state: a push overrides a drain, so a simultaneous transfer + push keeps vld high.
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (push_i) begin
         vld_d  = 1'b1;
         data_d = data_i;
      end else if (vld_q && out_rdy_i) begin
         vld_d = 1'b0;
      end
   end

   // Register with synchronous active-high reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/rle_enc_param.sv
// Parametrised run-length encoder: {last, symbol} stream in, {last, count, symbol} runs out.
module rle_enc_param
   import rle_pkg::*;
#(
   parameter int unsigned SYMBOL_WIDTH = 1,
   parameter int unsigned COUNT_WIDTH  = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [SYMBOL_WIDTH:0]               rle__input_r,
   input  logic                                rle__input_r_vld,
   output logic                                rle__input_r_rdy,
   output logic [SYMBOL_WIDTH+COUNT_WIDTH:0]   rle__output_s,
   output logic                                rle__output_s_vld,
   input  logic                                rle__output_s_rdy
);

   localparam int unsigned DataW = SYMBOL_WIDTH + COUNT_WIDTH + 1;

   typedef logic [SYMBOL_WIDTH-1:0] sym_t;
   typedef logic [COUNT_WIDTH-1:0]  cnt_t;
   typedef logic [DataW-1:0]        data_t;

   localparam cnt_t MaxCnt = '1;

   rle_state_t state_q, state_d;
   sym_t       cur_sym_q, cur_sym_d;
   cnt_t       cur_cnt_q, cur_cnt_d;
   // Held low through reset and the first edge after it, so rdy never depends on reset itself.
   logic       rdy_en_q;

   logic  can_push;
   logic  accept;
   logic  in_last;
   sym_t  in_sym;
   logic  push;
   logic  push_last;
   cnt_t  push_cnt;
   sym_t  push_sym;
   data_t push_data;

   assign in_last          = rle__input_r[SYMBOL_WIDTH];
   assign in_sym           = rle__input_r[SYMBOL_WIDTH-1:0];
   assign rle__input_r_rdy = rdy_en_q && (state_q != StFlush) && can_push;
   assign accept           = rle__input_r_vld && rle__input_r_rdy;
   assign push_data        = data_t'(rle_pack(push_last, MaxFieldW'(push_cnt),
                                              MaxFieldW'(push_sym), SYMBOL_WIDTH, COUNT_WIDTH));

   // Run tracking FSM: decides when a run closes and what descriptor to emit.
   always_comb begin
      state_d   = state_q;
      cur_sym_d = cur_sym_q;
      cur_cnt_d = cur_cnt_q;
      push      = 1'b0;
      push_last = 1'b0;
      push_cnt  = cur_cnt_q;
      push_sym  = cur_sym_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_last) begin
                  push      = 1'b1;
                  push_last = 1'b1;
                  push_cnt  = cnt_t'(1);
                  push_sym  = in_sym;
               end else begin
                  cur_sym_d = in_sym;
                  cur_cnt_d = cnt_t'(1);
                  state_d   = StRun;
               end
            end
         end
         StRun: begin
            if (accept) begin
               if (in_sym == cur_sym_q && cur_cnt_q != MaxCnt) begin
                  if (in_last) begin
                     push      = 1'b1;
                     push_last = 1'b1;
                     push_cnt  = cur_cnt_q + cnt_t'(1);
                     state_d   = StIdle;
                  end else begin
                     cur_cnt_d = cur_cnt_q + cnt_t'(1);
                  end
               end else begin
                  // Saturated or symbol change: close the current run, open a new one of 1.
                  push      = 1'b1;
                  cur_sym_d = in_sym;
                  cur_cnt_d = cnt_t'(1);
                  state_d   = in_last ? StFlush : StRun;
               end
            end
         end
         StFlush: begin
            if (can_push) begin
               push      = 1'b1;
               push_last = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-high reset; reset drops any open run.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cur_sym_q <= '0;
         cur_cnt_q <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_sym_q <= cur_sym_d;
         cur_cnt_q <= cur_cnt_d;
         rdy_en_q  <= 1'b1;
      end
   end

   rle_out_reg #(
      .DataW (DataW)
   ) u_out_reg (
      .clk_i      (clk),
      .reset_i    (reset),
      .push_i     (push),
      .data_i     (push_data),
      .can_push_o (can_push),
      .out_data_o (rle__output_s),
      .out_vld_o  (rle__output_s_vld),
      .out_rdy_i  (rle__output_s_rdy)
   );

endmodule
